// File: rtl/rx_smi_stream_arbiter_if.sv
// Stream bundle for the RX SMI arbiter: the two sample-FIFO read ports and the
// byte-wide output stream towards the SMI read path.
interface rx_smi_stream_arbiter_if;
    logic        fifo_09_empty;
    logic        fifo_09_pull;
    logic [31:0] fifo_09_pulled_data;
    logic        fifo_24_empty;
    logic        fifo_24_pull;
    logic [31:0] fifo_24_pulled_data;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_first;
    logic        channel;

    modport master (
        input  fifo_09_empty, fifo_09_pulled_data,
        input  fifo_24_empty, fifo_24_pulled_data,
        input  byte_ready,
        output fifo_09_pull, fifo_24_pull,
        output byte_data, byte_valid, byte_first, channel
    );

    modport slave (
        output fifo_09_empty, fifo_09_pulled_data,
        output fifo_24_empty, fifo_24_pulled_data,
        output byte_ready,
        input  fifo_09_pull, fifo_24_pull,
        input  byte_data, byte_valid, byte_first, channel
    );
endinterface

// File: rtl/rx_smi_stream_arbiter.sv
// Arbitrates between the 0.9 GHz and 2.4 GHz RX FIFOs and serializes each
// pulled 32-bit word MSB-first into four bytes on a valid/ready stream.
module rx_smi_stream_arbiter #(
    parameter int BURST_WORDS = 4,
    parameter int CNT_W       = 16
) (
    input  logic                          i_sys_clk,
    input  logic                          i_rst_b,
    input  logic [1:0]                    i_mode,
    rx_smi_stream_arbiter_if.master       smi,
    output logic                          o_busy,
    output logic [CNT_W-1:0]              o_words_09,
    output logic [CNT_W-1:0]              o_words_24
);
    typedef enum logic [1:0] {IDLE, PULL, LATCH, SEND} state_t;

    localparam logic [7:0] BURST_MAX = 8'(BURST_WORDS);

    state_t      state;
    state_t      state_next;
    logic        chan;
    logic        last_ch;
    logic [7:0]  burst_cnt;
    logic [31:0] shift;
    logic [1:0]  byte_idx;
    logic        grant;
    logic        grant_ch;
    logic        grant_restart;
    logic        cur_empty;
    logic        oth_empty;

    assign cur_empty = last_ch ? smi.fifo_24_empty : smi.fifo_09_empty;
    assign oth_empty = last_ch ? smi.fifo_09_empty : smi.fifo_24_empty;

    // A burst count of 0 means no burst is in progress on last_ch (only true
    // after reset), so interleaving opens on the channel opposite last_ch.
    always_comb begin
        grant         = 1'b0;
        grant_ch      = last_ch;
        grant_restart = 1'b0;
        case (i_mode)
            2'b01: begin
                if (!smi.fifo_09_empty) begin
                    grant         = 1'b1;
                    grant_ch      = 1'b0;
                    grant_restart = (last_ch != 1'b0);
                end
            end
            2'b10: begin
                if (!smi.fifo_24_empty) begin
                    grant         = 1'b1;
                    grant_ch      = 1'b1;
                    grant_restart = (last_ch != 1'b1);
                end
            end
            2'b11: begin
                if (!cur_empty && burst_cnt != 8'd0 && burst_cnt < BURST_MAX) begin
                    grant    = 1'b1;
                    grant_ch = last_ch;
                end else if (!oth_empty) begin
                    grant         = 1'b1;
                    grant_ch      = ~last_ch;
                    grant_restart = 1'b1;
                end else if (!cur_empty) begin
                    grant         = 1'b1;
                    grant_ch      = last_ch;
                    grant_restart = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        smi.fifo_09_pull = 1'b0;
        smi.fifo_24_pull = 1'b0;
        smi.byte_valid   = 1'b0;
        smi.byte_first   = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = PULL;
                end
            end
            PULL: begin
                smi.fifo_09_pull = ~chan;
                smi.fifo_24_pull = chan;
                state_next       = LATCH;
            end
            LATCH: begin
                state_next = SEND;
            end
            SEND: begin
                smi.byte_valid = 1'b1;
                smi.byte_first = (byte_idx == 2'd0);
                if (smi.byte_ready && byte_idx == 2'd3) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign smi.byte_data = shift[31:24];
    assign smi.channel   = chan;
    assign o_busy        = (state != IDLE);

    // Grant bookkeeping, word capture, byte shifting and the statistics counters.
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_b) begin
            chan       <= 1'b0;
            last_ch    <= 1'b1;
            burst_cnt  <= 8'd0;
            shift      <= 32'd0;
            byte_idx   <= 2'd0;
            o_words_09 <= '0;
            o_words_24 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        chan    <= grant_ch;
                        last_ch <= grant_ch;
                        if (grant_restart) begin
                            burst_cnt <= 8'd0;
                        end
                    end
                end
                LATCH: begin
                    shift    <= chan ? smi.fifo_24_pulled_data : smi.fifo_09_pulled_data;
                    byte_idx <= 2'd0;
                end
                SEND: begin
                    if (smi.byte_ready) begin
                        shift    <= {shift[23:0], 8'h00};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            if (chan) begin
                                o_words_24 <= o_words_24 + 1'b1;
                            end else begin
                                o_words_09 <= o_words_09 + 1'b1;
                            end
                            if (burst_cnt < BURST_MAX) begin
                                burst_cnt <= burst_cnt + 8'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
